// File: rtl/i2c_slave_regfile.sv
// I2C target, oversampled on clk, driving a byte-pointer register-bank interface.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchroniser.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         NUM_REGS   = 16,
    parameter int         PTR_RESET  = 0,
    localparam int        PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic [PTR_W-1:0] reg_ptr,
    input  logic [7:0]       reg_rd_data,
    output logic             reg_wr_en,
    output logic [7:0]       reg_wr_data,
    output logic             busy,
    output logic             xfer_done,
    output logic [3:0]       state
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_IGNORE    = 4'd2;
    localparam logic [3:0] S_ADDR_ACK  = 4'd3;
    localparam logic [3:0] S_PTR       = 4'd4;
    localparam logic [3:0] S_PTR_ACK   = 4'd5;
    localparam logic [3:0] S_WDATA     = 4'd6;
    localparam logic [3:0] S_WDATA_ACK = 4'd7;
    localparam logic [3:0] S_RDATA     = 4'd8;
    localparam logic [3:0] S_RACK      = 4'd9;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_v, sda_v, scl_p, sda_p;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // A level must be seen on two of the last three samples before it propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_v    <= 1'b1;
            sda_v    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_v    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_v    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_v = scl_sync[1];
    assign sda_v = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_p <= scl_v;
            sda_p <= sda_v;
        end
    end

    assign scl_rise = scl_v & ~scl_p;
    assign scl_fall = ~scl_v & scl_p;
    assign start_ev = scl_v & scl_p & sda_p & ~sda_v;
    assign stop_ev  = scl_v & scl_p & ~sda_p & sda_v;

    logic [6:0]       shreg;
    logic [7:0]       rx_byte;
    logic [2:0]       cnt;
    logic             phase, rw, ptr_inc;
    logic [PTR_W-1:0] ptr_next, ptr_load;

    assign rx_byte  = {shreg, sda_v};
    assign ptr_next = (reg_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : reg_ptr + PTR_W'(1);
    assign ptr_load = PTR_W'(int'(rx_byte) % NUM_REGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sda_oe      <= 1'b0;
            reg_ptr     <= PTR_W'(PTR_RESET);
            reg_wr_en   <= 1'b0;
            reg_wr_data <= 8'h00;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            shreg       <= 7'h00;
            cnt         <= 3'd0;
            phase       <= 1'b0;
            rw          <= 1'b0;
            ptr_inc     <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            xfer_done <= 1'b0;
            ptr_inc   <= 1'b0;
            if (ptr_inc) reg_ptr <= ptr_next;
            // Bus conditions override whatever the byte engine is doing.
            if (start_ev) begin
                state  <= S_ADDR;
                cnt    <= 3'd7;
                sda_oe <= 1'b0;
                phase  <= 1'b0;
            end else if (stop_ev) begin
                state     <= S_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                reg_ptr   <= PTR_W'(PTR_RESET);
                xfer_done <= busy;
                phase     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_IGNORE: sda_oe <= 1'b0;
                    S_ADDR, S_PTR, S_WDATA: if (scl_rise) begin
                        shreg <= rx_byte[6:0];
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            if (state == S_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'h00) begin
                                    busy  <= 1'b1;
                                    rw    <= rx_byte[0];
                                    state <= S_ADDR_ACK;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= S_IGNORE;
                                end
                            end else if (state == S_PTR) begin
                                reg_ptr <= ptr_load;
                                state   <= S_PTR_ACK;
                            end else begin
                                reg_wr_data <= rx_byte;
                                reg_wr_en   <= 1'b1;
                                ptr_inc     <= 1'b1;
                                state       <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            phase  <= 1'b0;
                            sda_oe <= 1'b0;
                            cnt    <= 3'd7;
                            if (state == S_ADDR_ACK && rw) begin
                                shreg  <= reg_rd_data[6:0];
                                sda_oe <= ~reg_rd_data[7];
                                state  <= S_RDATA;
                            end else if (state == S_ADDR_ACK) begin
                                state <= S_PTR;
                            end else begin
                                state <= S_WDATA;
                            end
                        end
                    end
                    S_RDATA: if (scl_fall) begin
                        if (cnt != 3'd0) begin
                            sda_oe <= ~shreg[6];
                            shreg  <= {shreg[5:0], 1'b0};
                            cnt    <= cnt - 3'd1;
                        end else begin
                            sda_oe  <= 1'b0;
                            reg_ptr <= ptr_next;
                            state   <= S_RACK;
                        end
                    end
                    S_RACK: begin
                        // phase 0 waits for the master's ACK bit, phase 1 for the fall that starts the next byte
                        if (!phase) begin
                            if (scl_rise) begin
                                if (!sda_v) begin
                                    phase <= 1'b1;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= S_IGNORE;
                                end
                            end
                        end else if (scl_fall) begin
                            phase  <= 1'b0;
                            shreg  <= reg_rd_data[6:0];
                            sda_oe <= ~reg_rd_data[7];
                            cnt    <= 3'd7;
                            state  <= S_RDATA;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-level I2C master, host register bank and a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    localparam int         Q         = 6;
    localparam int         NREG      = 16;
    localparam logic [6:0] ADDR      = 7'h2A;
    localparam logic [3:0] IDLE_CODE = 4'd0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, reg_wr_en, busy, xfer_done;
    logic [3:0] reg_ptr, state;
    logic [7:0] reg_rd_data, reg_wr_data;

    logic [7:0] bank [NREG];
    logic       pl_en = 1'b0;
    logic [3:0] pl_idx = 4'd0;
    logic [7:0] pl_val = 8'd0;

    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  m_bank [NREG];
    int          m_ptr = 0;
    int          m_done = 0;
    logic        m_busy = 1'b0;
    int          done_cnt = 0;
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    assign sda_line    = sda_m & ~sda_oe;
    assign reg_rd_data = bank[reg_ptr];

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .reg_ptr(reg_ptr), .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en),
        .reg_wr_data(reg_wr_data), .busy(busy), .xfer_done(xfer_done), .state(state)
    );

    always @(posedge clk) begin
        if (reg_wr_en) bank[reg_ptr] <= reg_wr_data;
        else if (pl_en) bank[pl_idx] <= pl_val;
    end

    always @(negedge clk) begin
        if (reg_wr_en) got_q.push_back({reg_ptr, reg_wr_data});
        if (xfer_done) done_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [7:0] val);
        pl_idx = 4'(idx);
        pl_val = val;
        pl_en  = 1'b1;
        wait_clk(1);
        pl_en  = 1'b0;
        m_bank[idx] = val;
    endtask

    task automatic bus_start();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // One SCL period; glitch pulls SCL low for a single clk during the high phase.
    task automatic bit_xfer(input logic b, input logic glitch, output logic s);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clk(2); scl_m = 1'b0; wait_clk(1); scl_m = 1'b1; wait_clk(Q - 3);
        end else begin
            wait_clk(Q);
        end
        s = sda_line; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], i == gbit, s);
        bit_xfer(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(nack, 1'b0, s);
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, " wr count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, " wr ptr/data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic end_txn(input string tag);
        bus_stop();
        if (m_busy) m_done++;
        m_busy = 1'b0;
        m_ptr  = 0;
        check_eq({tag, " xfer_done"}, done_cnt, m_done);
        check_eq({tag, " ptr reset"}, reg_ptr, m_ptr);
        check_eq({tag, " busy idle"}, busy, m_busy);
        check_writes(tag);
    endtask

    // START, address+W, pointer, then every byte of tx_q; gbit >= 0 glitches that bit of the first byte.
    task automatic txn_write(input logic [6:0] addr, input logic [7:0] ptr, input int gbit, input bit do_stop);
        logic       ack, match;
        logic [7:0] d;
        match = (addr == ADDR && addr != 7'h00);
        bus_start();
        send_byte({addr, 1'b0}, -1, ack);
        check_eq("addr_w ack", ack, !match);
        m_busy = match;
        send_byte(ptr, -1, ack);
        check_eq("ptr ack", ack, !match);
        if (match) m_ptr = ptr % NREG;
        foreach (tx_q[i]) begin
            d = tx_q[i];
            send_byte(d, (i == 0) ? gbit : -1, ack);
            if (gbit >= 0 && i == 0) begin
`ifndef I2C_SLAVE_GLITCH_FILTER_EN
                d = {d[7], d[7:1]};  // the extra SCL rise samples the MSB twice
`endif
            end else begin
                check_eq("data ack", ack, !match);
            end
            if (match) begin
                exp_q.push_back({4'(m_ptr), d});
                m_bank[m_ptr] = d;
                m_ptr = (m_ptr + 1) % NREG;
            end
        end
        if (do_stop) end_txn("wr");
    endtask

    task automatic txn_read(input logic [6:0] addr, input int n, input bit rstart);
        logic       ack, match;
        logic [7:0] d;
        match = (addr == ADDR);
        if (rstart) bus_rstart(); else bus_start();
        send_byte({addr, 1'b1}, -1, ack);
        check_eq("addr_r ack", ack, !match);
        m_busy = match;
        if (match) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(i == n - 1, d);
                check_eq("rd data", d, m_bank[m_ptr]);
                m_ptr = (m_ptr + 1) % NREG;
            end
            m_busy = 1'b0;
            check_eq("busy after nack", busy, m_busy);
            check_eq("ptr after read", reg_ptr, m_ptr);
        end
        end_txn("rd");
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       s;
        logic [6:0] a;
        int         kind;

        for (int i = 0; i < NREG; i++) preload(i, 8'($urandom));
        wait_clk(2);
        check_eq("rst sda_oe", sda_oe, 0);
        check_eq("rst reg_ptr", reg_ptr, 0);
        check_eq("rst reg_wr_en", reg_wr_en, 0);
        check_eq("rst reg_wr_data", reg_wr_data, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst xfer_done", xfer_done, 0);
        check_eq("rst state", state, IDLE_CODE);
        rst_n = 1'b1;
        wait_clk(4);

        tx_q = {};
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h5A);
        txn_write(ADDR, 8'h03, -1, 1'b1);

        preload(15, 8'h11);
        preload(0, 8'h22);
        preload(1, 8'h33);
        tx_q.delete();
        txn_write(ADDR, 8'h0F, -1, 1'b0);
        txn_read(ADDR, 3, 1'b1);

        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        tx_q.push_back(8'h12);
        tx_q.push_back(8'h34);
        txn_write(7'h2B, 8'h01, -1, 1'b1);
        check_eq("wrong addr oe_seen", oe_seen, 0);
        check_eq("wrong addr busy_seen", busy_seen, 0);

        tx_q.delete();
        txn_write(ADDR, 8'h05, -1, 1'b0);
        for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), 1'b0, s);
        end_txn("stop mid byte");
        check_eq("stop mid byte state", state, IDLE_CODE);

        preload(7, 8'h3C);
        txn_write(ADDR, 8'h07, -1, 1'b0);
        bus_rstart();
        send_byte({ADDR, 1'b1}, -1, ack);
        check_eq("rd addr ack", ack, 0);
        check_eq("rd first bit drive", sda_oe, !m_bank[7][7]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("sda_oe in reset", sda_oe, 0);
        check_eq("busy in reset", busy, 0);
        check_eq("ptr in reset", reg_ptr, 0);
        m_busy = 1'b0;
        m_ptr  = 0;
        wait_clk(3);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(2);
        scl_m = 1'b1;
        wait_clk(Q);
        check_eq("state after reset", state, IDLE_CODE);
        tx_q.delete();
        tx_q.push_back(8'($urandom));
        txn_write(ADDR, 8'($urandom), -1, 1'b1);
        txn_read(ADDR, 2, 1'b0);

        tx_q.delete();
        tx_q.push_back(8'hA5);
        txn_write(ADDR, 8'h02, 7, 1'b1);

        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 3);
            tx_q.delete();
            repeat ($urandom_range(1, 4)) tx_q.push_back(8'($urandom));
            case (kind)
                0: txn_write(ADDR, 8'($urandom), -1, 1'b1);
                1: begin
                    tx_q.delete();
                    txn_write(ADDR, 8'($urandom), -1, 1'b0);
                    txn_read(ADDR, $urandom_range(1, 4), 1'b1);
                end
                2: txn_read(ADDR, $urandom_range(1, 4), 1'b0);
                default: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == ADDR) a = 7'h00;
                    txn_write(a, 8'($urandom), -1, 1'b1);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
